stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-way registered stream multiplexer with valid/ready handshakes on every input channel and on the output.
- Operates in one of two modes, chosen at run time: explicit channel select, or fair round-robin arbitration across all valid channels.
- Sits between multiple producer streams and one shared consumer.
- Output is a single-stage register that sustains one transfer per clock.

Parameters:
- WIDTH, 4, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH) (minimum 1), width of the select and channel-ID fields.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = select mode, 1 = round-robin mode
- sel  in  SELW  channel index used in select mode
- in_valid  in  NCH  per-channel valid
- in_data  in  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- in_last  in  NCH  per-channel end-of-packet marker
- in_ready  out  NCH  per-channel ready (one-hot or zero)
- out_valid  out  1  output valid
- out_data  out  WIDTH  output data
- out_last  out  1  last flag of the registered beat
- out_ch  out  SELW  source channel of the registered beat
- out_ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_ch=0, rr pointer=0, lock cleared. in_ready is 0 while rst_n=0.
- Load enable: load = !out_valid || out_ready.
- Grant:
  - At most one channel g is granted per cycle.
  - in_ready[g] = load; all other in_ready bits are 0.
  - in_ready is combinational from state, mode, sel and in_valid. Valid-to-ready dependency is allowed; ready never feeds valid.
- Select mode (mode=0):
  - g = sel, when in_valid[sel]=1.
  - If sel >= NCH, or in_valid[sel]=0, there is no grant and no transfer.
- Round-robin mode (mode=1):
  - g = first valid channel searching ptr, ptr+1, ..., NCH-1, 0, ..., wrapping.
  - On each accepted transfer, ptr <= g+1 (mod NCH). ptr is unchanged otherwise.
  - No valid inputs means no grant.
- Transfer: when in_valid[g] && in_ready[g], the next cycle has out_valid=1, out_data=in_data[g], out_last=in_last[g], out_ch=g. Latency is 1 clock.
- If load=1 and there is no grant, out_valid <= 0.
- Backpressure: while out_valid && !out_ready, all output registers hold and in_ready=0.
- Simultaneous: the output drains and a new beat loads in the same cycle when out_ready=1, giving full throughput.
- Mode or sel change: takes effect on the next grant decision. A beat already in the output register is unaffected.
- Reset mid-transfer drops the registered beat. No recovery is required.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined (packet lock):
  - Once a beat with in_last=0 is accepted from channel g, grant stays locked to g, ignoring mode, sel and the rr pointer.
  - The lock releases after the beat with in_last=1 from g is accepted.
  - While locked and in_valid[g]=0, no other channel is granted.
  - The lock register resets to 0.
  - ptr updates only on the releasing beat.
- Undefined: in_last is forwarded to out_last but does not affect arbitration.

Decomposition:
- Package stream_mux_pkg:
  - MODE_SEL=1'b0 and MODE_RR=1'b1 constants.
  - Function for the SELW minimum-1 computation.
- Sub-module rr_arbiter (parameter NCH):
  - Inputs: req[NCH-1:0], ptr.
  - Outputs: one-hot gnt and encoded index.
  - Purely combinational, reused for round-robin grant.
- Top level holds the ptr/lock registers, the output register and the mode muxing.

Test Plan:
- Reset/idle: hold rst_n=0, drive in_valid=4'b1111 → in_ready=0, out_valid=0. Release with mode=1, out_ready=1 → first beat is from ch0 at cycle 1, out_ch=0.
- Round-robin fairness: NCH=4, all valid, distinct data 0xA,0xB,0xC,0xD, out_ready=1 → out_ch sequence 0,1,2,3,0,... with one beat per clock and no gaps.
- Select mode: mode=0, sel=2, in_valid=4'b0110, in_data ch2=0x5 → out_data=0x5, out_ch=2, in_ready=4'b0100. Then sel=3 (channel not valid) → out_valid=0 next cycle.
- Backpressure: out_ready=0 for 3 cycles with a beat held → out_data stable, in_ready=0. Set out_ready=1 with ch1 valid → drain and reload in the same cycle.
- Wrap/sparse: mode=1, ptr=3, in_valid=4'b0010 → grant ch1, after which ptr=2. Also sel=3 with NCH=3 → no grant.
- Packet lock (STREAM_MUX_PKT_LOCK_EN): ch0 sends 3 beats (last on the 3rd) while ch1 is always valid → out_ch=0,0,0, then 1. Compile without the macro → out_ch alternates 0,1,0,1.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr block.
// Exports MODE_SEL/MODE_RR and selw_f() (select/ID width, minimum 1).
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int selw_f(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle: NCH valid/ready producer channels plus one output stream.
// slave = mux side (drives in_ready, out_*); master = producers/consumer side.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = selw_f(NCH)
);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_last;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first req at or after ptr, wrapping.
// Ports: req, ptr in; one-hot gnt, encoded idx, vld (any grant) out.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = selw_f(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] idx,
    output logic            vld
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        c   = 0;
        for (int i = 0; i < NCH; i++) begin
            c = (int'(ptr) + i) % NCH;
            if (!vld && req[c]) begin
                vld    = 1'b1;
                gnt[c] = 1'b1;
                idx    = SELW'(c);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-way registered stream mux: explicit select (mode=0) or round-robin (mode=1).
// Ports: clk, rst_n, mode, sel, bus (slave). STREAM_MUX_PKT_LOCK_EN enables packet lock.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = selw_f(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    stream_mux_rr_if.slave  bus
);

    logic [SELW-1:0] ptr;
    logic            load;
    logic            xfer;
    logic [NCH-1:0]  gnt_oh;
    logic [SELW-1:0] g_idx;
    logic            g_last;
    logic            adv;
    logic [SELW-1:0] ptr_nxt;
    logic [NCH-1:0]  rr_gnt;
    logic [SELW-1:0] rr_idx;
    logic            rr_vld;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            locked;
    logic [SELW-1:0] lock_ch;
`endif

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req (bus.in_valid),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .vld (rr_vld)
    );

    assign load = !bus.out_valid || bus.out_ready;

    always_comb begin
        gnt_oh = '0;
        g_idx  = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (locked) begin
            gnt_oh[lock_ch] = bus.in_valid[lock_ch];
            g_idx           = lock_ch;
        end else
`endif
        begin
            unique case (mode)
                MODE_SEL: begin
                    // sel values beyond NCH-1 match no channel
                    for (int i = 0; i < NCH; i++)
                        if (sel == SELW'(i))
                            gnt_oh[i] = bus.in_valid[i];
                    g_idx = sel;
                end
                MODE_RR: begin
                    gnt_oh = rr_vld ? rr_gnt : '0;
                    g_idx  = rr_idx;
                end
            endcase
        end
    end

    assign xfer   = load && (|gnt_oh);
    assign g_last = bus.in_last[g_idx];
    assign bus.in_ready = (load && rst_n) ? gnt_oh : '0;

    assign ptr_nxt = (g_idx == SELW'(NCH - 1)) ? '0 : g_idx + 1'b1;

`ifdef STREAM_MUX_PKT_LOCK_EN
    // pointer only moves once the whole packet has gone through
    assign adv = (mode == MODE_RR) && g_last;
`else
    assign adv = (mode == MODE_RR);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_ch    <= '0;
            ptr           <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            locked        <= 1'b0;
            lock_ch       <= '0;
`endif
        end else if (load) begin
            bus.out_valid <= xfer;
            if (xfer) begin
                bus.out_data <= bus.in_data[g_idx*WIDTH +: WIDTH];
                bus.out_last <= g_last;
                bus.out_ch   <= g_idx;
                if (adv)
                    ptr <= ptr_nxt;
`ifdef STREAM_MUX_PKT_LOCK_EN
                locked  <= !g_last;
                lock_ch <= g_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (NCH=4, WIDTH=4) with a queue-based model.
// Honours STREAM_MUX_PKT_LOCK_EN in the reference model.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int W = 4;
    localparam int N = 4;
    localparam int S = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode  = 1'b0;
    logic [S-1:0] sel   = '0;

    stream_mux_rr_if #(.WIDTH(W), .NCH(N), .SELW(S)) bus();

    stream_mux_rr #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int l;
        int c;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int passed = 0;

    int m_ptr  = 0;
    bit m_ov   = 0;
    bit m_lock = 0;
    int m_lch  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic int model_grant(input bit md, input int sl, input logic [N-1:0] v);
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (m_lock) return v[m_lch] ? m_lch : -1;
`endif
        if (md == 1'b0) begin
            if (sl < N && v[sl]) return sl;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic step(input bit md, input int sl, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input logic [N-1:0] l, input bit ordy);
        int  g;
        bit  ld;
        int  er;
        beat_t b;
        @(negedge clk);
        mode          = md;
        sel           = S'(sl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
        #1;
        if (!rst_n) begin
            chk("rst_in_ready", int'(bus.in_ready), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
        end else begin
            chk("out_valid", int'(bus.out_valid), int'(m_ov));
            g  = model_grant(md, sl, v);
            ld = !m_ov || ordy;
            er = (g >= 0 && ld) ? (1 << g) : 0;
            chk("in_ready", int'(bus.in_ready), er);
            if (ld) begin
                if (g >= 0) begin
                    b.d = int'(d[g*W +: W]);
                    b.l = int'(l[g]);
                    b.c = g;
                    sb.push_back(b);
`ifdef STREAM_MUX_PKT_LOCK_EN
                    if (md == MODE_RR && l[g]) m_ptr = (g + 1) % N;
                    m_lock = !l[g];
                    m_lch  = g;
`else
                    if (md == MODE_RR) m_ptr = (g + 1) % N;
`endif
                    m_ov = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
    endtask

    // Monitor: a beat drains at the coming posedge when valid and ready.
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", int'(bus.out_data), e.d);
                chk("out_last", int'(bus.out_last), e.l);
                chk("out_ch", int'(bus.out_ch), e.c);
            end
        end
    end

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 3; i++)
            step(1'b1, 0, 4'b1111, 16'hDCBA, 4'b1111, 1'b1);
        bus.in_valid = '0;
        rst_n = 1'b1;

        // round-robin over all four channels
        for (int i = 0; i < 8; i++)
            step(1'b1, 0, 4'b1111, 16'hDCBA, 4'b1111, 1'b1);

        // select mode, then an invalid selected channel
        step(1'b0, 2, 4'b0110, 16'h0532, 4'b1111, 1'b1);
        step(1'b0, 3, 4'b0110, 16'h0532, 4'b1111, 1'b1);
        step(1'b0, 3, 4'b0000, 16'h0000, 4'b1111, 1'b1);

        // backpressure then drain+reload together
        step(1'b0, 1, 4'b0010, 16'h0070, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1, 4'b0010, 16'h0090, 4'b1111, 1'b0);
        step(1'b0, 1, 4'b0010, 16'h00E0, 4'b1111, 1'b1);

        // sparse wrap: ch2 moves ptr to 3, then only ch1 valid
        step(1'b1, 0, 4'b0100, 16'h0300, 4'b1111, 1'b1);
        step(1'b1, 0, 4'b0010, 16'h0040, 4'b1111, 1'b1);
        step(1'b1, 0, 4'b1111, 16'h4321, 4'b1111, 1'b1);

        // ch0 three-beat packet against an always-valid ch1
        step(1'b1, 0, 4'b0000, 16'h0000, 4'b1111, 1'b1);
        step(1'b1, 0, 4'b0011, 16'h0051, 4'b0010, 1'b1);
        step(1'b1, 0, 4'b0011, 16'h0062, 4'b0010, 1'b1);
        step(1'b1, 0, 4'b0011, 16'h0073, 4'b0011, 1'b1);
        step(1'b1, 0, 4'b0011, 16'h0084, 4'b0011, 1'b1);
        step(1'b1, 0, 4'b0011, 16'h0095, 4'b0011, 1'b1);

        begin
            bit md;
            int sl;
            md = 1'b1;
            sl = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) md = ~md;
                if ($urandom_range(0, 7) == 0) sl = $urandom_range(0, 3);
                step(md, sl, N'($urandom()), (N*W)'($urandom()),
                     N'($urandom()), $urandom_range(0, 3) != 0);
            end
        end

        for (int i = 0; i < 4; i++)
            step(1'b1, 0, 4'b0000, 16'h0000, 4'b1111, 1'b1);
        @(negedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
